// File: rtl/mult_booth.sv
// Multicycle signed WIDTH x WIDTH radix-2 Booth multiplier; 2*WIDTH-bit product on HI/LO.
// Optional overflow flag port `ovf` is enabled by defining MULT_OVF_EN.
module mult_booth #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multControl,
    input  logic [WIDTH-1:0] aInput,
    input  logic [WIDTH-1:0] bInput,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
`ifdef MULT_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]              state_q, state_d;
    logic signed [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0]        q_q, q_d;
    logic                    q1_q, q1_d;
    logic signed [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        hi_q, hi_d, lo_q, lo_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic signed [WIDTH:0]   m_ext, sum;
`ifdef MULT_OVF_EN
    logic                    ovf_q, ovf_d;
`endif

    always_comb begin
        // A is one bit wider than M so that subtracting M = most-negative value stays exact
        m_ext = {m_q[WIDTH-1], m_q};
        sum   = a_q;
        case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_ext;
            2'b10:   sum = a_q - m_ext;
            default: sum = a_q;
        endcase

        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MULT_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (multControl) begin
                    m_d     = $signed(aInput);
                    q_d     = bInput;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!multControl) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    a_d   = {sum[WIDTH], sum[WIDTH:1]};
                    q_d   = {sum[0], q_q[WIDTH-1:1]};
                    q1_d  = q_q[0];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        hi_d    = a_d[WIDTH-1:0];
                        lo_d    = q_d;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
`ifdef MULT_OVF_EN
                        ovf_d   = (a_d[WIDTH-1:0] != {WIDTH{q_d[WIDTH-1]}});
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULT_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULT_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef MULT_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_mult_booth.sv
// Directed and randomized self-checking bench for mult_booth (checks ovf when MULT_OVF_EN is defined).
module tb_mult_booth;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        multControl = 1'b0;
    logic [31:0] aInput = '0;
    logic [31:0] bInput = '0;
    logic [31:0] HI, LO;
    logic        busy, done;
`ifdef MULT_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    mult_booth #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .multControl(multControl),
        .aInput(aInput), .bInput(bInput),
        .HI(HI), .LO(LO), .busy(busy), .done(done)
`ifdef MULT_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done, returning edges counted (max+1 if it never came)
    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n <= max);
    endtask

    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_p, input logic exp_ovf);
        int n;
        multControl = 1'b1;
        aInput = a;
        bInput = b;
        tick();
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        aInput = ~a;
        bInput = ~b;
        wait_done(40, n);
        multControl = 1'b0;
        chk({tag, "_lat"}, 64'(n + 1), 64'd33);
        chk({tag, "_prod"}, {HI, LO}, exp_p);
        chk({tag, "_nbusy"}, 64'(busy), 64'd0);
`ifdef MULT_OVF_EN
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) n_checks = n_checks;
`endif
        tick();
        chk({tag, "_done1cyc"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [63:0] vp [7];
        logic        vo [7];
        int          n;
        logic [63:0] old_p;

        va[0] = 32'd3;        vb[0] = 32'd5;        vp[0] = 64'h0000_0000_0000_000F; vo[0] = 1'b0;
        va[1] = 32'hFFFF_FFF9; vb[1] = 32'd6;       vp[1] = 64'hFFFF_FFFF_FFFF_FFD6; vo[1] = 1'b0;
        va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vp[2] = 64'h4000_0000_0000_0000; vo[2] = 1'b1;
        va[3] = 32'h7FFF_FFFF; vb[3] = 32'hFFFF_FFFF; vp[3] = 64'hFFFF_FFFF_8000_0001; vo[3] = 1'b0;
        va[4] = 32'h1234_5678; vb[4] = 32'd0;       vp[4] = 64'h0;                  vo[4] = 1'b0;
        va[5] = 32'hFFFF_FFFF; vb[5] = 32'hFFFF_FFFF; vp[5] = 64'h1;                vo[5] = 1'b0;
        va[6] = 32'h7FFF_FFFF; vb[6] = 32'h7FFF_FFFF; vp[6] = 64'h3FFF_FFFF_0000_0001; vo[6] = 1'b1;

        tick();
        tick();
        chk("rst_hilo", {HI, LO}, 64'h0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) do_mult($sformatf("vec%0d", i), va[i], vb[i], vp[i], vo[i]);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            longint      p;
            ra = $urandom();
            rb = $urandom();
            p  = longint'($signed(ra)) * longint'($signed(rb));
            do_mult($sformatf("rnd%0d", i), ra, rb, p, (p[63:32] != {32{p[31]}}));
        end

        // Abort at step 10: outputs keep the previous product
        old_p = {HI, LO};
        multControl = 1'b1; aInput = 32'd3; bInput = 32'd5;
        tick();
        for (int i = 0; i < 9; i++) tick();
        multControl = 1'b0;
        tick();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) n++;
        end
        chk("abort_nodone", 64'(n), 64'd0);
        chk("abort_hilo", {HI, LO}, old_p);

        // Reset at step 20 clears everything
        multControl = 1'b1; aInput = 32'd3; bInput = 32'd5;
        tick();
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b1;
        tick();
        chk("mrst_hilo", {HI, LO}, 64'h0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
`ifdef MULT_OVF_EN
        chk("mrst_ovf", 64'(ovf), 64'd0);
`endif
        reset = 1'b0;
        multControl = 1'b0;
        tick();

        // Back-to-back with multControl held high throughout
        multControl = 1'b1; aInput = 32'd2; bInput = 32'd2;
        tick();
        aInput = 32'd4; bInput = 32'd4;
        wait_done(40, n);
        chk("b2b_lat1", 64'(n), 64'd32);
        chk("b2b_lo1", {HI, LO}, 64'd4);
        wait_done(40, n);
        chk("b2b_gap", 64'(n), 64'd33);
        chk("b2b_lo2", {HI, LO}, 64'd16);
        multControl = 1'b0;
        tick();
        chk("b2b_done_end", 64'(done), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
